// File: rtl/ventana_medicion_if.sv
// Control/status bundle between the heart-rate controller and the measurement-window timer.
interface ventana_medicion_if #(
    parameter int SEC_W = 8
);
    logic             start;
    logic             abort;
    logic             en_cont;
    logic [SEC_W-1:0] win_len;
    logic             tick_1s;
    logic             done;
    logic             busy;
    logic [SEC_W-1:0] seg_rest;
    logic [SEC_W-1:0] seg_trans;

    modport master (
        output start, abort, en_cont, win_len,
        input  tick_1s, done, busy, seg_rest, seg_trans
    );

    modport slave (
        input  start, abort, en_cont, win_len,
        output tick_1s, done, busy, seg_rest, seg_trans
    );
endinterface

// File: rtl/ventana_medicion.sv
// Measurement-window timer: 1 s tick prescaler plus an N-second window with start/abort/pause.
// Define VENTANA_AUTORECARGA_EN for back-to-back windows that reload at expiry instead of stopping.
module ventana_medicion #(
    parameter int CLK_HZ   = 50000000,
    parameter int WINDOW_S = 60,
    parameter int SEC_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    ventana_medicion_if.slave bus
);
    localparam int               PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]    PRE_TC  = PW'(CLK_HZ - 1);
    localparam logic [SEC_W-1:0] WIN_DEF = SEC_W'(WINDOW_S);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [SEC_W-1:0] len_q, len_d;
    logic [SEC_W-1:0] seg_rest_q, seg_rest_d;
    logic [SEC_W-1:0] seg_trans_q, seg_trans_d;
    logic             tick_1s_q, tick_1s_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic             tick_evt;
    logic             expire;

    // Abort outranks every other event, so it masks both start acceptance and ticks.
    assign accept   = (state_q == IDLE) && bus.start && !bus.abort;
    assign tick_evt = (state_q == RUN) && bus.en_cont && !bus.abort && (presc_q == PRE_TC);
    assign expire   = tick_evt && (seg_rest_q == SEC_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            len_q       <= WIN_DEF;
            seg_rest_q  <= '0;
            seg_trans_q <= '0;
            tick_1s_q   <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            len_q       <= len_d;
            seg_rest_q  <= seg_rest_d;
            seg_trans_q <= seg_trans_d;
            tick_1s_q   <= tick_1s_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (expire) begin
`ifdef VENTANA_AUTORECARGA_EN
                    state_d = RUN;
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        presc_d     = presc_q;
        len_d       = len_q;
        seg_rest_d  = seg_rest_q;
        seg_trans_d = seg_trans_q;
        tick_1s_d   = 1'b0;
        done_d      = 1'b0;
        busy_d      = (state_d == RUN);

        if (bus.abort) begin
            presc_d    = '0;
            seg_rest_d = '0;
        end else if (accept) begin
            len_d       = (bus.win_len == '0) ? WIN_DEF : bus.win_len;
            seg_rest_d  = len_d;
            seg_trans_d = '0;
            presc_d     = '0;
        end else if ((state_q == RUN) && bus.en_cont) begin
            presc_d = (presc_q == PRE_TC) ? '0 : presc_q + PW'(1);
            if (tick_evt) begin
                tick_1s_d = 1'b1;
                if (expire) begin
                    done_d = 1'b1;
`ifdef VENTANA_AUTORECARGA_EN
                    seg_rest_d  = len_q;
                    seg_trans_d = '0;
`else
                    seg_rest_d  = '0;
                    seg_trans_d = len_q;
`endif
                end else begin
                    seg_rest_d  = seg_rest_q - SEC_W'(1);
                    seg_trans_d = seg_trans_q + SEC_W'(1);
                end
            end
        end
    end

    assign bus.tick_1s   = tick_1s_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.seg_rest  = seg_rest_q;
    assign bus.seg_trans = seg_trans_q;
endmodule
